// File: rtl/keypad_pkg.sv
// keypad_pkg: shared states, row drive patterns, key map and column decode for the keypad scanner
package keypad_pkg;
  typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, REL_DB} state_e;
  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } col_hit_t;
  localparam logic [3:0] ROW_DRIVE [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  localparam logic [3:0] KEYMAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };
  // Valid only when exactly one column is pulled low; idx is that column
  function automatic col_hit_t onehot_low(input logic [3:0] col);
    col_hit_t h;
    logic [3:0] c;
    c = ~col;
    h.valid = (c != 4'd0) && ((c & (c - 4'd1)) == 4'd0);
    h.idx = c[0] ? 2'd0 : c[1] ? 2'd1 : c[2] ? 2'd2 : 2'd3;
    return h;
  endfunction
endpackage

// File: rtl/keypad_code_lut.sv
// keypad_code_lut: row/column index to 4-bit keycode
module keypad_code_lut
  import keypad_pkg::*;
(
  input  logic [1:0] row_i,
  input  logic [1:0] col_i,
  output logic [3:0] code_o
);
  assign code_o = KEYMAP[row_i][col_i];
endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: row scanner with press/release debounce and two-digit key history
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 4096,
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col_sync,
  output logic [3:0] r_sel,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic [3:0] right,
  output logic [3:0] left
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(DEBOUNCE_CYC + 1);
  state_e          state_q, state_d;
  logic [1:0]      row_q, row_d, col_q, col_d;
  logic [3:0]      pat_q, pat_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic [BW-1:0]   db_q, db_d, db_inc;
  logic [3:0]      r_sel_q, r_sel_d, key_code_q, key_code_d, right_q, right_d, left_q, left_d;
  logic            key_valid_q, key_valid_d, tick, db_done, accept;
  logic [3:0]      code;
  col_hit_t        hit;
  keypad_code_lut u_lut (.row_i(row_q), .col_i(col_q), .code_o(code));
  assign hit     = onehot_low(col_sync);
  assign tick    = dwell_q == DW'(SCAN_DIV - 1);
  assign db_inc  = db_q + 1'b1;
  assign db_done = db_inc == BW'(DEBOUNCE_CYC);
  assign accept  = (state_q == PRESS_DB) && (col_sync == pat_q) && db_done;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SCAN;
      row_q       <= 2'd0;
      col_q       <= 2'd0;
      pat_q       <= 4'hF;
      dwell_q     <= '0;
      db_q        <= '0;
      r_sel_q     <= ROW_DRIVE[0];
      key_valid_q <= 1'b0;
      key_code_q  <= 4'h0;
      right_q     <= 4'h0;
      left_q      <= 4'h0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      pat_q       <= pat_d;
      dwell_q     <= dwell_d;
      db_q        <= db_d;
      r_sel_q     <= r_sel_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      right_q     <= right_d;
      left_q      <= left_d;
    end
  end
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    pat_d   = pat_q;
    dwell_d = dwell_q;
    db_d    = db_q;
    case (state_q)
      SCAN: begin
        dwell_d = tick ? '0 : dwell_q + 1'b1;
        if (tick && hit.valid) begin
          state_d = PRESS_DB;
          col_d   = hit.idx;
          pat_d   = col_sync;
          db_d    = '0;
        end else if (tick) row_d = row_q + 2'd1;
      end
      PRESS_DB: begin
        db_d = db_inc;
        if (col_sync != pat_q) begin
          state_d = SCAN;
          row_d   = row_q + 2'd1;
          dwell_d = '0;
          db_d    = '0;
        end else if (db_done) begin
          state_d = HELD;
          db_d    = '0;
        end
      end
      HELD: begin
        state_d = (col_sync == 4'hF) ? REL_DB : HELD;
        db_d    = '0;
      end
      REL_DB: begin
        db_d = db_inc;
        if (col_sync != 4'hF) begin
          state_d = HELD;
          db_d    = '0;
        end else if (db_done) begin
          state_d = SCAN;
          row_d   = row_q + 2'd1;
          dwell_d = '0;
          db_d    = '0;
        end
      end
      default: state_d = SCAN;
    endcase
  end
  always_comb begin
    r_sel_d     = ROW_DRIVE[row_d];
    key_valid_d = accept;
    key_code_d  = accept ? code : key_code_q;
    right_d     = accept ? code : right_q;
    left_d      = accept ? right_q : left_q;
  end
  assign r_sel     = r_sel_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign right     = right_q;
  assign left      = left_q;
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: directed scan, press, release, bounce, ghost and reset checks
module tb_keypad_scan_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] col_sync, col_drv, r_sel, key_code, right, left;
  logic       key_valid, use_model;
  int         p_row, p_col, checks = 0, errors = 0, n;
  function automatic logic [3:0] cold(input int i);
    return ~(4'b0001 << i);
  endfunction
  // Keypad model: the pressed key pulls its column low only while its row is driven
  assign col_sync = use_model ? ((r_sel === cold(p_row)) ? cold(p_col) : 4'hF) : col_drv;
  keypad_scan_ctrl #(.SCAN_DIV(8), .DEBOUNCE_CYC(4)) dut (
    .clk(clk), .reset(reset), .col_sync(col_sync), .r_sel(r_sel),
    .key_valid(key_valid), .key_code(key_code), .right(right), .left(left)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_rsel"}, r_sel, 4'b1110);
    chk({tag, "_kv"}, key_valid, 0);
    chk({tag, "_code"}, key_code, 0);
    chk({tag, "_right"}, right, 0);
    chk({tag, "_left"}, left, 0);
  endtask
  initial begin
    reset = 1'b1; use_model = 1'b0; col_drv = 4'hF; p_row = 0; p_col = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_reset("rst");
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      chk($sformatf("scan_rsel%0d", k), r_sel, cold((k / 8) % 4));
      chk($sformatf("scan_kv%0d", k), key_valid, 0);
    end
    use_model = 1'b1; p_row = 1; p_col = 1;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      chk($sformatf("p5_kv%0d", j), key_valid, (j == 12) ? 1 : 0);
      chk($sformatf("p5_rsel%0d", j), r_sel, 4'b1101);
    end
    chk("p5_code", key_code, 4'h5);
    chk("p5_right", right, 4'h5);
    chk("p5_left", left, 4'h0);
    use_model = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      chk($sformatf("rel_rsel%0d", j), r_sel, (j < 5) ? 4'b1101 : 4'b1011);
      chk($sformatf("rel_kv%0d", j), key_valid, 0);
    end
    use_model = 1'b1; p_row = 0; p_col = 3;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!key_valid && n < 40);
    chk("pa_latency", n, 23);
    chk("pa_code", key_code, 4'hA);
    chk("pa_right", right, 4'hA);
    chk("pa_left", left, 4'h5);
    use_model = 1'b0;
    @(negedge clk);
    chk("pa_single_pulse", key_valid, 0);
    chk("pa_frozen", r_sel, 4'b1110);
    repeat (3) @(negedge clk);
    chk("pa_reldb", r_sel, 4'b1110);
    @(negedge clk);
    chk("pa_resume", r_sel, 4'b1101);
    for (int j = 0; j < 48; j++) begin
      chk($sformatf("bounce_kv%0d", j), key_valid, 0);
      if (j == 8) chk("bounce_frozen", r_sel, 4'b1101);
      if (j == 10) chk("bounce_abort_adv", r_sel, 4'b1011);
      col_drv = (r_sel === 4'b1101 && ((j + 1) / 2) % 2 == 0) ? 4'b1101 : 4'hF;
      @(negedge clk);
    end
    for (int j = 0; j < 24; j++) begin
      chk($sformatf("ghost_kv%0d", j), key_valid, 0);
      if (j == 9) chk("ghost_row3", r_sel, 4'b0111);
      if (j == 10) chk("ghost_adv", r_sel, 4'b1110);
      col_drv = (r_sel === 4'b0111) ? 4'b1100 : 4'hF;
      @(negedge clk);
    end
    col_drv = 4'hF;
    chk("ghost_code", key_code, 4'hA);
    chk("ghost_right", right, 4'hA);
    chk("ghost_left", left, 4'h5);
    use_model = 1'b1; p_row = 1; p_col = 1;
    repeat (4) @(negedge clk);
    chk("mid_rsel", r_sel, 4'b1101);
    chk("mid_kv", key_valid, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; use_model = 1'b0;
    chk_reset("midrst");
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      chk($sformatf("post_kv%0d", j), key_valid, 0);
    end
    chk("post_right", right, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
